// File: rtl/tff_ctrl_pkg.sv
// rtl/tff_ctrl_pkg.sv - shared states, defaults and width helper for the TFF counter run controller
package tff_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CLR  = 2'b01,
        ST_RUN  = 2'b10,
        ST_HOLD = 2'b11
    } state_t;

    localparam int DEF_WIDTH    = 3;
    localparam int DEF_PRESCALE = 4;

    // Prescaler register width; a one-bit register is kept even when PRESCALE is 1.
    function automatic int ps_width(input int prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - modulo-PRESCALE tick generator with freeze and restart
module tick_prescaler
    import tff_ctrl_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE,
    localparam int PS_W = ps_width(PRESCALE)
) (
    input  logic            clk,
    input  logic            clear,
    input  logic            run,
    input  logic            hold,
    input  logic            restart,
    output logic            tick,
    output logic [PS_W-1:0] ps_cnt
);

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic at_last;

    assign at_last = (ps_cnt == PS_LAST);
    assign tick    = run & ~hold & at_last;

    // hold only blocks the wrap, so a tick masked by pause/stop is retried rather than lost.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            ps_cnt <= '0;
        end else if (restart) begin
            ps_cnt <= '0;
        end else if (run) begin
            if (!at_last) begin
                ps_cnt <= ps_cnt + PS_W'(1);
            end else if (!hold) begin
                ps_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/tff_counter_ctrl.sv
// rtl/tff_counter_ctrl.sv - run controller driving enable/clear of a T-flip-flop counter
module tff_counter_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_o
);

    localparam int               PS_W    = ps_width(PRESCALE);
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] tgt_r;
    logic [PS_W-1:0]  ps_cnt;
    logic             tick;
    logic             in_run;
    logic             in_clr;
    logic             launch;
    logic             terminal;

    assign in_run = (state == ST_RUN);
    assign in_clr = (state == ST_CLR);
    assign launch = (state == ST_IDLE) & start & ~stop & (target != '0);

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .clear   (clear),
        .run     (in_run),
        .hold    (pause | stop),
        .restart (in_clr),
        .tick    (tick),
        .ps_cnt  (ps_cnt)
    );

    assign cnt_en   = in_run & (ps_cnt == PS_LAST) & ~pause & ~stop;
    // Terminal fires on the increment that moves the counter onto tgt_r.
    assign terminal = tick & (cnt_q == tgt_r - ONE);

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (launch) state_nx = ST_CLR;
            end
            ST_CLR: begin
                state_nx = stop ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                if (stop)          state_nx = ST_IDLE;
                else if (terminal) state_nx = auto_reload ? ST_CLR : ST_IDLE;
                else if (pause)    state_nx = ST_HOLD;
            end
            ST_HOLD: begin
                if (stop)        state_nx = ST_IDLE;
                else if (!pause) state_nx = ST_RUN;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state <= ST_IDLE;
            tgt_r <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= terminal;
            if (launch) tgt_r <= target;
        end
    end

    assign cnt_clr = in_clr | clear;
    assign busy    = (state != ST_IDLE);
    assign state_o = state;

endmodule

// File: tb/tb_tff_counter_ctrl.sv
// tb/tb_tff_counter_ctrl.sv - directed self-checking bench for tff_counter_ctrl
module tb_tff_counter_ctrl;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       start = 1'b0;
    logic       start1 = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic       auto_reload = 1'b0;
    logic [2:0] target = 3'd0;

    logic [2:0] q4 = 3'd0;
    logic [2:0] q1 = 3'd0;
    logic       en4, clr4, busy4, done4;
    logic       en1, clr1, busy1, done1;
    logic [1:0] st4, st1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    tff_counter_ctrl #(.WIDTH(3), .PRESCALE(4)) u_dut4 (
        .clk(clk), .clear(clear), .start(start), .stop(stop), .pause(pause),
        .auto_reload(auto_reload), .target(target), .cnt_q(q4),
        .cnt_en(en4), .cnt_clr(clr4), .busy(busy4), .done(done4), .state_o(st4)
    );

    tff_counter_ctrl #(.WIDTH(3), .PRESCALE(1)) u_dut1 (
        .clk(clk), .clear(clear), .start(start1), .stop(stop), .pause(pause),
        .auto_reload(auto_reload), .target(target), .cnt_q(q1),
        .cnt_en(en1), .cnt_clr(clr1), .busy(busy1), .done(done1), .state_o(st1)
    );

    // Load counters: async clear, increment on enable.
    always @(posedge clk or posedge clr4) begin
        if (clr4) q4 <= 3'd0;
        else if (en4) q4 <= q4 + 3'd1;
    end

    always @(posedge clk or posedge clr1) begin
        if (clr1) q1 <= 3'd0;
        else if (en1) q1 <= q1 + 3'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic       start;
        logic       stop;
        logic [2:0] tgt;
        logic [1:0] exp_state;
        logic       exp_busy;
        logic       exp_clr;
    } vec_t;

    vec_t vt[8];

    initial begin
        int errs;
        int dcyc;
        int dcount;
        int first_en;
        int en_count;
        int dq[$];

        vt[0] = '{1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0};
        vt[1] = '{1'b1, 1'b1, 3'd3, 2'd0, 1'b0, 1'b0};
        vt[2] = '{1'b1, 1'b0, 3'd3, 2'd1, 1'b1, 1'b1};
        vt[3] = '{1'b0, 1'b1, 3'd3, 2'd0, 1'b0, 1'b0};
        vt[4] = '{1'b1, 1'b0, 3'd1, 2'd1, 1'b1, 1'b1};
        vt[5] = '{1'b0, 1'b0, 3'd1, 2'd2, 1'b1, 1'b0};
        vt[6] = '{1'b0, 1'b1, 3'd1, 2'd0, 1'b0, 1'b0};
        vt[7] = '{1'b0, 1'b0, 3'd1, 2'd0, 1'b0, 1'b0};

        // Reset state
        #12;
        chk("rst_state", st4, 0);
        chk("rst_cnt_en", en4, 0);
        chk("rst_cnt_clr", clr4, 1);
        chk("rst_busy", busy4, 0);
        chk("rst_done", done4, 0);
        chk("rst_q", q4, 0);
        clear = 1'b0;
        tick();

        // One-shot run, target 5
        target = 3'd5; auto_reload = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("oneshot_clr_state", st4, 1);
        chk("oneshot_clr_pulse", clr4, 1);
        errs = 0; dcyc = 0; dcount = 0;
        for (int c = 2; c <= 26; c++) begin
            tick();
            if (en4 !== ((c <= 21 && (c - 2) % 4 == 3) ? 1'b1 : 1'b0)) errs++;
            if (clr4 !== 1'b0) errs++;
            if (c <= 21 && q4 !== 3'((c - 2) / 4)) errs++;
            if (done4) begin dcount++; dcyc = c; end
        end
        chk("oneshot_pattern_errs", errs, 0);
        chk("oneshot_done_cycle", dcyc, 22);
        chk("oneshot_done_count", dcount, 1);
        chk("oneshot_end_state", st4, 0);
        chk("oneshot_end_busy", busy4, 0);
        chk("oneshot_end_q", q4, 5);

        // Auto-reload, target 3
        target = 3'd3; auto_reload = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        errs = 0;
        dq.delete();
        for (int c = 2; c <= 41; c++) begin
            tick();
            if (clr4 !== done4) errs++;
            if (q4 > 3'd3) errs++;
            if ((c == 13 || c == 26 || c == 39) && q4 !== 3'd2) errs++;
            if (done4) dq.push_back(c);
        end
        chk("reload_pattern_errs", errs, 0);
        chk("reload_done_count", dq.size(), 3);
        if (dq.size() == 3) begin
            chk("reload_done0", dq[0], 14);
            chk("reload_done1", dq[1], 27);
            chk("reload_done2", dq[2], 40);
        end
        auto_reload = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("reload_stop_state", st4, 0);

        // Pause for 20 cycles at Q=2
        target = 3'd5; start = 1'b1;
        tick();
        start = 1'b0;
        errs = 0; dcyc = 0; dcount = 0;
        for (int c = 2; c <= 45; c++) begin
            tick();
            pause = (c >= 11 && c <= 30);
            #1;
            if (en4 !== ((c == 5 || c == 9 || c == 33 || c == 37 || c == 41) ? 1'b1 : 1'b0)) errs++;
            if (c >= 12 && c <= 31 && (st4 !== 2'd3 || q4 !== 3'd2)) errs++;
            if (c == 11 && st4 !== 2'd2) errs++;
            if (done4) begin dcount++; dcyc = c; end
        end
        pause = 1'b0;
        chk("pause_pattern_errs", errs, 0);
        chk("pause_done_cycle", dcyc, 42);
        chk("pause_done_count", dcount, 1);
        chk("pause_end_q", q4, 5);

        // Stop at Q=4 with target 6, on a would-be increment cycle
        target = 3'd6; start = 1'b1;
        tick();
        start = 1'b0;
        errs = 0; dcount = 0;
        for (int c = 2; c <= 40; c++) begin
            tick();
            stop = (c == 21);
            #1;
            if (c == 21) begin
                chk("stop_q_before", q4, 4);
                chk("stop_en_masked", en4, 0);
            end
            if (c == 22) chk("stop_next_state", st4, 0);
            if (c >= 22 && (st4 !== 2'd0 || q4 !== 3'd4)) errs++;
            if (done4) dcount++;
        end
        stop = 1'b0;
        chk("stop_hold_errs", errs, 0);
        chk("stop_no_done", dcount, 0);

        // Ignored and priority commands from the vector table
        for (int i = 0; i < 8; i++) begin
            start = vt[i].start; stop = vt[i].stop; target = vt[i].tgt;
            tick();
            start = 1'b0; stop = 1'b0;
            #1;
            chk($sformatf("vec%0d_state", i), st4, vt[i].exp_state);
            chk($sformatf("vec%0d_busy", i), busy4, vt[i].exp_busy);
            chk($sformatf("vec%0d_clr", i), clr4, vt[i].exp_clr);
        end

        // start while busy must not retarget the run
        target = 3'd2; start = 1'b1;
        tick();
        start = 1'b0;
        dcyc = 0; dcount = 0;
        for (int c = 2; c <= 16; c++) begin
            tick();
            start = (c == 5);
            if (c == 5) target = 3'd7;
            #1;
            if (done4) begin dcount++; dcyc = c; end
        end
        start = 1'b0;
        chk("busy_start_done_cycle", dcyc, 10);
        chk("busy_start_done_count", dcount, 1);
        chk("busy_start_q", q4, 2);
        chk("busy_start_state", st4, 0);

        // PRESCALE=1, target 7
        target = 3'd7; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("ps1_clr_state", st1, 1);
        errs = 0; en_count = 0; dcyc = 0; first_en = 0;
        for (int c = 2; c <= 12; c++) begin
            tick();
            if (en1 !== ((c >= 2 && c <= 8) ? 1'b1 : 1'b0)) errs++;
            if (en1 === 1'b1) begin
                en_count++;
                if (first_en == 0) first_en = c;
            end
            if (done1) dcyc = c;
        end
        chk("ps1_en_errs", errs, 0);
        chk("ps1_en_count", en_count, 7);
        chk("ps1_first_en", first_en, 2);
        chk("ps1_done_cycle", dcyc, 9);
        chk("ps1_q", q1, 7);

        // Asynchronous reset mid-run at Q=3
        target = 3'd6; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 2; c <= 15; c++) tick();
        chk("areset_pre_state", st4, 2);
        chk("areset_pre_q", q4, 3);
        #3;
        clear = 1'b1;
        #1;
        chk("areset_state", st4, 0);
        chk("areset_cnt_en", en4, 0);
        chk("areset_cnt_clr", clr4, 1);
        chk("areset_busy", busy4, 0);
        chk("areset_q", q4, 0);
        #2;
        clear = 1'b0;
        tick();
        chk("areset_after_state", st4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
